// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: redirect/stall controls from D, the instruction-memory
// port, and the F/D pipeline outputs plus the activity counters.
// master = the surrounding pipeline / memory side, slave = pc_fetch_stage.
interface pc_fetch_stage_if;
  logic        stall;
  logic [1:0]  npc_sel;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] IR_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        fetch_err_D;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  modport master (
    output stall, npc_sel, branch_target, jump_target, imem_instr,
    input  imem_addr, IR_D, PC_D, PC8_D, fetch_err_D, fetch_cnt, stall_cnt
  );

  modport slave (
    input  stall, npc_sel, branch_target, jump_target, imem_instr,
    output imem_addr, IR_D, PC_D, PC8_D, fetch_err_D, fetch_cnt, stall_cnt
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// F stage of the 5-stage MIPS pipeline: program counter, next-PC select,
// instruction fetch into the F/D register, and fetch/stall counters.
// There is no flush: the architected delay slot always executes.
// Optional feature macro: PC_ALIGN_CHECK_EN -- flags misaligned or
// out-of-range fetches, replacing the captured word with a nop.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic           clk,
  input  logic           reset,
  pc_fetch_stage_if.slave bus
);

  logic [31:0] pc_f;
  logic [31:0] npc;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        fetch_err_d;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic        fetch_bad;

  assign bus.imem_addr   = pc_f;
  assign bus.IR_D        = ir_d;
  assign bus.PC_D        = pc_d;
  assign bus.PC8_D       = pc8_d;
  assign bus.fetch_err_D = fetch_err_d;
  assign bus.fetch_cnt   = fetch_cnt;
  assign bus.stall_cnt   = stall_cnt;

  // Next-PC source select; 2'b11 falls back to the sequential path.
  always_comb begin
    // NOTE: npc gets a value before the case so every path assigns it and no latch is inferred.
    npc = pc_f + 32'd4;
    case (bus.npc_sel)
      2'b01:   npc = bus.branch_target;
      2'b10:   npc = bus.jump_target;
      default: ;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // Bounds held in 33 bits so RESET_PC + 4*IM_WORDS cannot wrap.
  localparam logic [32:0] im_lo = {1'b0, RESET_PC};
  localparam logic [32:0] im_hi = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

  // Fetch fault: misaligned PC or PC outside the instruction memory window.
  always_comb begin
    fetch_bad = (pc_f[1:0] != 2'b00) ||
                ({1'b0, pc_f} <  im_lo) ||
                ({1'b0, pc_f} >= im_hi);
  end
`else
  // IM_WORDS only matters to the range check.
  localparam int unsigned im_words_unused = IM_WORDS;
  assign fetch_bad = 1'b0;
`endif

  // PC, F/D register and counters; a stall freezes all but stall_cnt.
  // NOTE: non-blocking assignments so every register samples pre-edge values (PC_D gets the old PC_F).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f        <= RESET_PC;
      ir_d        <= '0;
      pc_d        <= '0;
      pc8_d       <= '0;
      fetch_err_d <= 1'b0;
      fetch_cnt   <= '0;
      stall_cnt   <= '0;
    end else if (bus.stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      pc_f        <= npc;
      ir_d        <= fetch_bad ? 32'h0 : bus.imem_instr;
      pc_d        <= pc_f;
      pc8_d       <= pc_f + 32'd8;
      fetch_err_d <= fetch_bad;
      fetch_cnt   <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- F-stage of the 5-stage MIPS pipeline: holds the program counter and the F/D pipeline register.
- Chooses the next PC from three sources: sequential PC+4, the branch target from D, and the jump/jr target produced by the next-PC unit in D.
- Drives the instruction-memory address and captures the fetched word into D.
- Has stall support and fetch/stall counters; no flush, because the architected delay slot always executes.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_WORDS, 1024, instruction-memory size in words; used only by the optional range check.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  freeze PC_F and the F/D register this cycle.
- npc_sel  in  2  next-PC source: 00 = PC_F+4, 01 = branch_target, 10 = jump_target, 11 = treated as 00.
- branch_target  in  32  taken-branch target computed in D.
- jump_target  in  32  j/jal/jr target from the next-PC unit in D.
- imem_addr  out  32  current fetch address, equal to PC_F.
- imem_instr  in  32  combinational instruction-memory read data for imem_addr.
- IR_D  out  32  instruction register, D stage.
- PC_D  out  32  PC of IR_D.
- PC8_D  out  32  PC_D+8, link value for jal/jalr.
- fetch_err_D  out  1  fetch-fault flag for IR_D.
- fetch_cnt  out  32  count of non-stalled cycles since reset.
- stall_cnt  out  32  count of stalled cycles since reset.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - PC_F = RESET_PC.
  - IR_D = 0 (nop), PC_D = 0, PC8_D = 0, fetch_err_D = 0.
  - fetch_cnt = 0, stall_cnt = 0.
- imem_addr = PC_F, combinational.
- Each rising edge with reset low and stall low:
  - PC_F <= mux(npc_sel). Sequential value is PC_F+4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
  - IR_D <= imem_instr; PC_D <= PC_F; PC8_D <= PC_F+8 (modulo 2^32).
  - fetch_cnt <= fetch_cnt+1, wrapping.
- Each rising edge with reset low and stall high:
  - PC_F, IR_D, PC_D, PC8_D and fetch_err_D hold.
  - stall_cnt <= stall_cnt+1, wrapping.
  - npc_sel, branch_target and jump_target are ignored. The redirecting instruction stays frozen in D and re-presents its redirect once the stall drops.
- Timing and latency:
  - A redirect asserted in cycle N with stall low loads PC_F at edge N.
  - The word fetched during cycle N (the delay slot) is captured into D normally.
  - Fetch-to-D latency is one cycle.
- Target inputs are used verbatim; no alignment is forced.
- stall and a redirect in the same cycle: stall wins.
- No internal state other than the listed registers.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- With the macro defined:
  - On a non-stalled edge, if PC_F[1:0] != 0, or PC_F < RESET_PC, or PC_F >= RESET_PC+4*IM_WORDS, then IR_D <= 0 and fetch_err_D <= 1.
  - Otherwise fetch_err_D <= 0.
  - PC_D and PC8_D update normally in both cases.
- Without the macro: fetch_err_D is constant 0 and IR_D always takes imem_instr.

Test Plan:
- Reset release with stall=0, npc_sel=00, imem returning 32'h2408_0005:
  - imem_addr = 3000, 3004, 3008 on successive cycles.
  - One cycle after the first fetch, IR_D = 32'h2408_0005, PC_D = 3000, PC8_D = 3008.
  - fetch_cnt increments each cycle.
- Jump: at PC_F=3010, npc_sel=10, jump_target=32'h0000_3040:
  - Next imem_addr = 3040.
  - Word fetched at 3010 (delay slot) appears in IR_D with PC_D = 3010.
- Stall: at PC_F=3020, stall=1 for 3 cycles with npc_sel=01, branch_target=3100:
  - PC_F and IR_D hold for all 3 cycles; stall_cnt += 3.
  - On the first unstalled edge with npc_sel=01, PC_F = 3100.
- Wrap: force the sequential path from PC_F = 32'hFFFF_FFFC -> PC_F = 0, PC8_D = 32'h0000_0004.
- Asynchronous reset pulse mid-cycle while stalled:
  - PC_F = 3000, IR_D = 0, both counters = 0 immediately, without waiting for a clock edge.
- With PC_ALIGN_CHECK_EN defined: jump_target = 32'h0000_3042:
  - Next edge gives IR_D = 0, fetch_err_D = 1.
  - A following in-range fetch at 3004 clears fetch_err_D to 0.
